// File: rtl/compare_stim_checker_if.sv
// Comparator-facing bus of compare_stim_checker: operand pair out, LED-coded result back.
interface compare_stim_checker_if;
    logic [1:0] a_out;
    logic [1:0] b_out;
    logic [2:0] led_in;

    modport master (output a_out, output b_out, input led_in);
    modport slave  (input a_out, input b_out, output led_in);
endinterface

// File: rtl/compare_stim_checker.sv
// Sweeps all 16 (a,b) pairs into a 2-bit magnitude comparator and checks its LED result.
// Optional macro COMPARE_CHK_STOP_ON_FAIL_EN: halt on first mismatch, hold failing vector.
module compare_stim_checker #(
    parameter int unsigned DWELL          = 600_000,
    parameter int unsigned SETTLE         = 4,
    parameter bit          LED_ACTIVE_LOW = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    compare_stim_checker_if.master        cmp,
    output logic                          busy,
    output logic                          done,
    output logic                          pass,
    output logic [4:0]                    err_cnt,
    output logic                          fail_vld,
    output logic [1:0]                    fail_a,
    output logic [1:0]                    fail_b
);

    localparam int unsigned CntW = $clog2(DWELL + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [3:0]      idx_q, idx_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [4:0]      err_q, err_d;
    logic            fail_vld_q, fail_vld_d;
    logic [1:0]      fail_a_q, fail_a_d;
    logic [1:0]      fail_b_q, fail_b_d;
    logic [2:0]      led_q;

    logic [1:0]      vec_a, vec_b;
    logic [2:0]      led_hi, led_exp;
    logic            compare_now, mismatch, last_slot;

    assign vec_a   = idx_q[1:0];
    assign vec_b   = idx_q[3:2];
    assign led_hi  = LED_ACTIVE_LOW ? ~led_q : led_q;
    assign led_exp = {vec_a > vec_b, vec_a == vec_b, vec_a < vec_b};

    // The start edge occupies slot 0 of vector 0, so within a vector cnt runs 1..DWELL;
    // this puts each vector change at edge 1+idx*DWELL and its compare SETTLE edges later.
    assign compare_now = (state_q == StRun) && (cnt_q == CntW'(SETTLE));
    assign mismatch    = compare_now && (led_hi != led_exp);
    assign last_slot   = (cnt_q == CntW'(DWELL));

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        fail_vld_d = fail_vld_q;
        fail_a_d   = fail_a_q;
        fail_b_d   = fail_b_q;
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d    = StRun;
                    idx_d      = 4'd0;
                    cnt_d      = '0;
                    err_d      = 5'd0;
                    fail_vld_d = 1'b0;
                    fail_a_d   = 2'd0;
                    fail_b_d   = 2'd0;
                end
            end
            StRun: begin
                cnt_d = cnt_q + CntW'(1);
                if (mismatch) begin
                    if (err_q != 5'd31) begin
                        err_d = err_q + 5'd1;
                    end
                    if (!fail_vld_q) begin
                        fail_vld_d = 1'b1;
                        fail_a_d   = vec_a;
                        fail_b_d   = vec_b;
                    end
                end
                if (last_slot) begin
                    cnt_d = CntW'(1);
                    if (idx_q == 4'd15) begin
                        state_d = StDone;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
`ifdef COMPARE_CHK_STOP_ON_FAIL_EN
                if (mismatch) begin
                    state_d = StDone;
                    cnt_d   = cnt_q;
                end
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            idx_q      <= 4'd0;
            cnt_q      <= '0;
            err_q      <= 5'd0;
            fail_vld_q <= 1'b0;
            fail_a_q   <= 2'd0;
            fail_b_q   <= 2'd0;
            led_q      <= 3'd0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            fail_vld_q <= fail_vld_d;
            fail_a_q   <= fail_a_d;
            fail_b_q   <= fail_b_d;
            led_q      <= cmp.led_in;
        end
    end

    logic drive_vec;
`ifdef COMPARE_CHK_STOP_ON_FAIL_EN
    assign drive_vec = (state_q == StRun) || ((state_q == StDone) && fail_vld_q);
`else
    assign drive_vec = (state_q == StRun);
`endif

    assign cmp.a_out = drive_vec ? vec_a : 2'd0;
    assign cmp.b_out = drive_vec ? vec_b : 2'd0;
    assign busy      = (state_q == StRun);
    assign done      = (state_q == StDone);
    assign pass      = done && (err_q == 5'd0);
    assign err_cnt   = err_q;
    assign fail_vld  = fail_vld_q;
    assign fail_a    = fail_a_q;
    assign fail_b    = fail_b_q;

endmodule

// File: tb/tb_compare_stim_checker.sv
// Scoreboard bench for compare_stim_checker (DWELL=8, SETTLE=3, active-low LEDs).
module tb_compare_stim_checker;

    localparam int unsigned Dwell  = 8;
    localparam int unsigned Settle = 3;

    typedef struct {
        int edge_n;
        int a;
        int b;
    } vec_t;

    typedef struct {
        int edge_n;
        int err;
        int pss;
        int fvld;
        int fa;
        int fb;
    } res_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       busy, done, pass, fail_vld;
    logic [4:0] err_cnt;
    logic [1:0] fail_a, fail_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int run_base = 0;
    int mode = 0;  // 0 correct comparator, 1 tied "equal", 2 gt/lt swapped

    vec_t vq[$];
    res_t rq[$];

    compare_stim_checker_if cif ();

    compare_stim_checker #(
        .DWELL          (Dwell),
        .SETTLE         (Settle),
        .LED_ACTIVE_LOW (1'b1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .cmp      (cif.master),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .err_cnt  (err_cnt),
        .fail_vld (fail_vld),
        .fail_a   (fail_a),
        .fail_b   (fail_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Comparator stand-in; result driven active-low.
    logic [2:0] cmp_hi;
    always_comb begin
        cmp_hi = 3'b000;
        case (mode)
            0: cmp_hi = {cif.a_out > cif.b_out, cif.a_out == cif.b_out, cif.a_out < cif.b_out};
            1: cmp_hi = 3'b010;
            2: cmp_hi = {cif.a_out < cif.b_out, cif.a_out == cif.b_out, cif.a_out > cif.b_out};
            default: cmp_hi = 3'b000;
        endcase
        cif.led_in = ~cmp_hi;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_run(input int done_edge, input int err, input int pss, input int fv,
                            input int fa, input int fb, input int nvec);
        res_t r;
        for (int i = 0; i < nvec; i++) begin
            vec_t v;
            v.edge_n = (i == 0) ? 0 : i * Dwell + 1;
            v.a = i % 4;
            v.b = i / 4;
            vq.push_back(v);
        end
        r.edge_n = done_edge;
        r.err    = err;
        r.pss    = pss;
        r.fvld   = fv;
        r.fa     = fa;
        r.fb     = fb;
        rq.push_back(r);
    endtask

    // Start sampled at the next rising edge, which becomes edge 0 of the run.
    task automatic start_run();
        @(negedge clk);
        run_base = cyc + 1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic poke_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!done) begin
            errors++;
            checks++;
            $display("FAIL %s_timeout: got done=0 expected done=1 within 400 cycles", name);
        end
        repeat (2) @(posedge clk);
        #1;
        chk({name, "_res_left"}, rq.size(), 0);
        chk({name, "_vec_left"}, vq.size(), 0);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_busy"}, int'(busy), 0);
        chk({name, "_done"}, int'(done), 0);
        chk({name, "_pass"}, int'(pass), 0);
        chk({name, "_err"}, int'(err_cnt), 0);
        chk({name, "_fvld"}, int'(fail_vld), 0);
        chk({name, "_fa"}, int'(fail_a), 0);
        chk({name, "_fb"}, int'(fail_b), 0);
        chk({name, "_a"}, int'(cif.a_out), 0);
        chk({name, "_b"}, int'(cif.b_out), 0);
    endtask

    // Monitor: pops a vector on each change of the driven pair, a result when done rises.
    initial begin
        logic busy_p, done_p;
        logic [3:0] ab_p;
        int en;
        vec_t v;
        res_t r;
        busy_p = 1'b0;
        done_p = 1'b0;
        ab_p   = 4'd0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                busy_p = 1'b0;
                done_p = 1'b0;
                continue;
            end
            en = cyc - run_base;
            if (busy && (!busy_p || {cif.b_out, cif.a_out} != ab_p)) begin
                if (vq.size() == 0) begin
                    chk("vec_unexpected_edge", en, -1);
                end else begin
                    v = vq.pop_front();
                    chk("vec_a", int'(cif.a_out), v.a);
                    chk("vec_b", int'(cif.b_out), v.b);
                    chk("vec_edge", en, v.edge_n);
                end
            end
            if (done && !done_p) begin
                if (rq.size() == 0) begin
                    chk("res_unexpected_edge", en, -1);
                end else begin
                    r = rq.pop_front();
                    chk("done_edge", en, r.edge_n);
                    chk("err_cnt", int'(err_cnt), r.err);
                    chk("pass", int'(pass), r.pss);
                    chk("fail_vld", int'(fail_vld), r.fvld);
                    chk("fail_a", int'(fail_a), r.fa);
                    chk("fail_b", int'(fail_b), r.fb);
                    chk("busy_in_done", int'(busy), 0);
                end
            end
            busy_p = busy;
            done_p = done;
            ab_p   = {cif.b_out, cif.a_out};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000 ns");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        chk_all_zero("reset");
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("idle");

        // Correct comparator: clean pass.
        mode = 0;
        push_run(129, 0, 1, 0, 0, 0, 16);
        start_run();
        wait_done("good");
        chk("good_done_a", int'(cif.a_out), 0);
        chk("good_done_b", int'(cif.b_out), 0);

        // Tied "equal": every unequal pair fails, first at (1,0).
        mode = 1;
`ifdef COMPARE_CHK_STOP_ON_FAIL_EN
        push_run(12, 1, 0, 1, 1, 0, 2);
`else
        push_run(129, 12, 0, 1, 1, 0, 16);
`endif
        start_run();
        wait_done("tied");
`ifdef COMPARE_CHK_STOP_ON_FAIL_EN
        chk("tied_hold_a", int'(cif.a_out), 1);
        chk("tied_hold_b", int'(cif.b_out), 0);
`else
        chk("tied_done_a", int'(cif.a_out), 0);
`endif

        // Swapped gt/lt, started from DONE: results cleared on the start edge.
        mode = 2;
`ifdef COMPARE_CHK_STOP_ON_FAIL_EN
        push_run(12, 1, 0, 1, 1, 0, 2);
`else
        push_run(129, 12, 0, 1, 1, 0, 16);
`endif
        start_run();
        chk("restart_err", int'(err_cnt), 0);
        chk("restart_fvld", int'(fail_vld), 0);
        chk("restart_done", int'(done), 0);
        chk("restart_busy", int'(busy), 1);
        wait_done("swap");

        // Start pulses at edges 20 and 60 are ignored.
        mode = 0;
        push_run(129, 0, 1, 0, 0, 0, 16);
        start_run();
        repeat (19) @(posedge clk);
        poke_start();
        repeat (39) @(posedge clk);
        poke_start();
        wait_done("ignore");

        // Asynchronous reset at edge 50 mid-run, then a clean run.
        push_run(129, 0, 1, 0, 0, 0, 16);
        start_run();
        repeat (49) @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        vq.delete();
        rq.delete();
        chk_all_zero("midrst");
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        push_run(129, 0, 1, 0, 0, 0, 16);
        start_run();
        wait_done("postrst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
